// File: rtl/rr_mux_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arb_if
// Brief    : N-channel valid/ready input bus and single registered output bus
// Revision : 1.0  initial release
// ============================================================================
interface rr_mux_arb_if #(
   parameter int WIDTH = 5,
   parameter int N     = 4,
   parameter int SELW  = (N > 1) ? $clog2(N) : 1
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_sel;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/rr_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arb
// Brief    : Round-robin N:1 arbiter/mux feeding a single-entry output register
// Revision : 1.0  initial release
// ============================================================================
module rr_mux_arb #(
   parameter int WIDTH = 5,
   parameter int N     = 4
) (
   input  wire logic     clk,
   input  wire logic     reset,
   rr_mux_arb_if.slave   bus
);
   localparam int c_selw = (N > 1) ? $clog2(N) : 1;

   logic [c_selw-1:0] r_ptr;
   logic [c_selw-1:0] r_sel;
   logic [WIDTH-1:0]  r_data;
   logic              r_valid;

   logic              w_free;
   logic              w_found;
   logic [c_selw-1:0] w_gnt;
   logic [c_selw:0]   w_k;
   logic [N-1:0]      w_ready;
   logic [WIDTH-1:0]  w_word;
   logic [c_selw-1:0] w_ptr_nxt;

   assign w_free = !r_valid || bus.out_ready;

   // Scan offsets from farthest to nearest so the channel closest to r_ptr wins.
   // The one-step modulo is enough because r_ptr < N keeps the sum below 2N.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_k     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         w_k = {1'b0, r_ptr} + (c_selw + 1)'(i);
         if (w_k >= (c_selw + 1)'(N)) begin
            w_k = w_k - (c_selw + 1)'(N);
         end
         if (bus.in_valid[w_k[c_selw-1:0]]) begin
            w_found = 1'b1;
            w_gnt   = w_k[c_selw-1:0];
         end
      end
   end

   always_comb begin
      w_word = '0;
      for (int k = 0; k < N; k++) begin
         if (w_gnt == c_selw'(k)) begin
            w_word = bus.in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (w_free && w_found && !reset) begin
         w_ready[w_gnt] = 1'b1;
      end
   end

   assign w_ptr_nxt = (w_gnt == c_selw'(N - 1)) ? '0 : w_gnt + c_selw'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr   <= '0;
         r_sel   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (w_free) begin
         if (w_found) begin
            r_data  <= w_word;
            r_sel   <= w_gnt;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_nxt;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_data  = r_data;
   assign bus.out_sel   = r_sel;
   assign bus.out_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arb
// Brief    : Scoreboard bench for rr_mux_arb (N=4 main instance, N=3 side instance)
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_mux_arb;
   localparam int W = 5;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rr_mux_arb_if #(.WIDTH(W), .N(N)) bus ();
   rr_mux_arb_if #(.WIDTH(W), .N(3)) bus3 ();

   rr_mux_arb #(.WIDTH(W), .N(N)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
   rr_mux_arb #(.WIDTH(W), .N(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

   typedef struct packed {
      logic [1:0]   sel;
      logic [W-1:0] data;
   } item_t;

   int    checks   = 0;
   int    failures = 0;
   item_t sbq[$];
   logic       m_valid;
   logic [1:0] m_ptr;

   function automatic int model_grant(input logic [N-1:0] v, input logic [1:0] p);
      for (int i = 0; i < N; i++) begin
         int k;
         k = (int'(p) + i) % N;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      sbq.delete();
      m_valid = 1'b0;
      m_ptr   = 2'd0;
   endtask

   // One clock of stimulus: inputs already applied; checks at negedge, returns at posedge+1.
   task automatic step();
      int         g;
      logic [N-1:0] exp_rdy;
      item_t      it;
      @(negedge clk);
      g = model_grant(bus.in_valid, m_ptr);
      exp_rdy = '0;
      if ((!m_valid || bus.out_ready) && g >= 0) exp_rdy[g] = 1'b1;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
         failures++;
         $display("FAIL in_ready got=%b exp=%b t=%0t", bus.in_ready, exp_rdy, $time);
      end
      checks++;
      if (bus.out_valid !== m_valid) begin
         failures++;
         $display("FAIL out_valid got=%b exp=%b t=%0t", bus.out_valid, m_valid, $time);
      end
      if (m_valid && bus.out_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=%0d exp=1 t=%0t", sbq.size(), $time);
         end else begin
            it = sbq.pop_front();
            checks++;
            if ({bus.out_sel, bus.out_data} !== it) begin
               failures++;
               $display("FAIL sb_word got=sel%0d/%0d exp=sel%0d/%0d t=%0t",
                        bus.out_sel, bus.out_data, it.sel, it.data, $time);
            end
         end
      end
      if (!m_valid || bus.out_ready) begin
         if (g >= 0) begin
            sbq.push_back({2'(g), bus.in_data[g*W +: W]});
            m_valid = 1'b1;
            m_ptr   = (g == N - 1) ? 2'd0 : 2'(g + 1);
         end else begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bus.in_valid  = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8 && (m_valid || sbq.size() != 0); i++) step();
      checks++;
      if (sbq.size() != 0 || m_valid) begin
         failures++;
         $display("FAIL drain got=%0d exp=0", sbq.size());
      end
   endtask

   task automatic chk_out(input string nm, input logic [1:0] s, input logic [W-1:0] d);
      checks++;
      if (bus.out_sel !== s || bus.out_data !== d || bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s got=v%b sel%0d/%0d exp=v1 sel%0d/%0d", nm,
                  bus.out_valid, bus.out_sel, bus.out_data, s, d);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_data = '1; bus.in_valid = '1; bus.out_ready = 1'b1;
      bus3.in_data = '1; bus3.in_valid = '1; bus3.out_ready = 1'b1;
      #3;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sel !== '0) begin
         failures++;
         $display("FAIL reset_out got=v%b %0d sel%0d exp=v0 0 sel0", bus.out_valid, bus.out_data, bus.out_sel);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== '0 || bus3.in_ready !== '0 || bus.out_valid !== 1'b0 || bus3.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold got=%b/%b exp=0000/000", bus.in_ready, bus3.in_ready);
      end
      bus.in_valid = '0; bus3.in_valid = '0;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_all_valid();
      logic [1:0]   es[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [W-1:0] ed[5] = '{5'd6, 5'd10, 5'd17, 5'd31, 5'd6};
      bus.in_data = {5'd31, 5'd17, 5'd10, 5'd6};
      bus.in_valid = 4'b1111;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_out("all_valid_seq", es[i], ed[i]);
      end
      drain();
   endtask

   task automatic test_stall();
      bus.in_data = {5'd3, 5'd2, 5'd10, 5'd6};
      bus.in_valid = 4'b0001;
      bus.out_ready = 1'b1;
      step();
      chk_out("stall_load", 2'd0, 5'd6);
      bus.in_valid = 4'b1110;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("stall_hold", 2'd0, 5'd6);
         checks++;
         if (bus.in_ready !== '0) begin
            failures++;
            $display("FAIL stall_ready got=%b exp=0000", bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      step();
      chk_out("stall_release", 2'd1, 5'd10);
      drain();
   endtask

   task automatic test_single_channel();
      bus.in_data = {5'd1, 5'd9, 5'd1, 5'd1};
      bus.in_valid = 4'b0100;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out("single_ch2", 2'd2, 5'd9);
      end
      drain();
   endtask

   task automatic test_wrap();
      bus.in_data = {5'd5, 5'd1, 5'd1, 5'd12};
      bus.in_valid = 4'b1001;
      bus.out_ready = 1'b1;
      step();
      chk_out("wrap_ch3", 2'd3, 5'd5);
      step();
      chk_out("wrap_ch0", 2'd0, 5'd12);
      drain();
   endtask

   task automatic test_async_reset();
      bus.in_data = {5'd3, 5'd1, 5'd21, 5'd1};
      bus.in_valid = 4'b0010;
      bus.out_ready = 1'b0;
      step();
      chk_out("areset_pre", 2'd1, 5'd21);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sel !== '0 || bus.in_ready !== '0) begin
         failures++;
         $display("FAIL areset_async got=v%b %0d sel%0d rdy%b exp=v0 0 sel0 rdy0000",
                  bus.out_valid, bus.out_data, bus.out_sel, bus.in_ready);
      end
      reset = 1'b0;
      model_reset();
      bus.in_data = {5'd3, 5'd1, 5'd7, 5'd1};
      bus.in_valid = 4'b1010;
      bus.out_ready = 1'b1;
      step();
      chk_out("areset_first", 2'd1, 5'd7);
      drain();
   endtask

   task automatic test_n3();
      logic [1:0] es[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
      bus3.in_data = {5'd3, 5'd2, 5'd1};
      bus3.in_valid = 3'b111;
      bus3.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (i < 4 && (bus3.out_sel !== es[i] || bus3.out_data !== W'(es[i] + 1) || bus3.out_valid !== 1'b1)) begin
            failures++;
            $display("FAIL n3_seq got=sel%0d/%0d exp=sel%0d/%0d", bus3.out_sel, bus3.out_data, es[i], es[i] + 1);
         end else if (bus3.out_sel >= 2'd3) begin
            failures++;
            $display("FAIL n3_range got=%0d exp=<3", bus3.out_sel);
         end
      end
      bus3.in_valid = '0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         bus.in_valid  = 4'($urandom);
         bus.in_data   = 20'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_all_valid();
      test_stall();
      test_single_channel();
      test_wrap();
      test_async_reset();
      test_n3();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter WIDTH, default 5, bit width of each data word.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16, non-power-of-2 values included.
REQ-003 Derived SELW = max(1, ceil(log2(N))), width of channel index.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  N*WIDTH  channel k word occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  channel k presents a word.
REQ-008 in_ready  output  N  channel k word is accepted this cycle (combinational).
REQ-009 out_data  output  WIDTH  registered selected word.
REQ-010 out_sel  output  SELW  index of channel that supplied out_data.
REQ-011 out_valid  output  1  out_data/out_sel hold a word.
REQ-012 out_ready  input  1  consumer takes the word this cycle.

Function
REQ-013 Output stage SHALL be a single-entry register; free = !out_valid || out_ready.
REQ-014 Round-robin pointer ptr (SELW bits, range 0..N-1) SHALL define highest-priority channel.
REQ-015 Grant g SHALL be first k with in_valid[k]=1 searching ptr, ptr+1, ..., wrapping N-1 -> 0.
REQ-016 in_ready[g] SHALL be 1 only when free=1 and a grant exists; all other in_ready bits 0.
REQ-017 in_ready SHALL depend on in_valid, ptr, out_valid, out_ready only, never on in_data.
REQ-018 On edge with free=1 and grant g: out_data<=word g, out_sel<=g, out_valid<=1, ptr<=(g==N-1)?0:g+1.
REQ-019 On edge with free=1 and no in_valid: out_valid<=0; out_data, out_sel, ptr unchanged.
REQ-020 On edge with out_valid=1, out_ready=0 (stall): out_data, out_sel, out_valid, ptr SHALL hold; in_ready=0.
REQ-021 Latency: word accepted on edge T SHALL appear with out_valid=1 after edge T (1 cycle).
REQ-022 Throughput: with out_ready held 1, one word per cycle SHALL transfer, no bubbles while any in_valid=1.
REQ-023 Simultaneous consume and accept (out_valid=1, out_ready=1, grant exists) SHALL replace the word in the same edge with no loss or duplication.
REQ-024 ptr SHALL advance only on acceptance; a stall or idle cycle SHALL NOT change it.
REQ-025 A channel holding in_valid=1 SHALL be granted within N acceptances (starvation-free).
REQ-026 in_valid deasserted before acceptance SHALL drop the request without side effect.
REQ-027 For N not a power of 2, ptr and out_sel SHALL never take values >= N.

Reset
REQ-028 reset=1 SHALL immediately force out_valid=0, out_data=0, out_sel=0, ptr=0, independent of clk.
REQ-029 While reset=1, in_ready SHALL be all 0.
REQ-030 Reset mid-transfer SHALL discard the held word; first grant after release SHALL start search at channel 0.

Verification (N=4, WIDTH=5)
REQ-031 All in_valid=4'b1111, words ch0..3 = 6,10,17,31, out_ready=1 -> out_sel sequence 0,1,2,3,0 with out_data 6,10,17,31,6 on consecutive cycles.
REQ-032 Word 6 latched from ch0, out_ready=0 for 3 cycles, in_valid=4'b1110 -> out_data=6, out_sel=0 stable, in_ready=0; on out_ready=1, next word is ch1=10 in same edge.
REQ-033 Only ch2 valid (word 9) for 4 cycles, out_ready=1 -> ch2 granted every cycle, out_data=9 each cycle, ptr=3.
REQ-034 ptr=3, in_valid=4'b1001 -> ch3 granted, ptr wraps to 0, next grant ch0.
REQ-035 reset asserted between edges with out_valid=1 -> out_valid=0, out_data=0 before next edge; after release with 4'b1010 valid, first grant ch1.
REQ-036 N=3 build, all valid -> out_sel cycles 0,1,2,0; out_sel never 3.
